// File: rtl/io_port_if.sv
// Control-unit strobes, address and the two external valid/ready streams of io_port.
// The shared data bus stays a plain inout on the module so it can be resolved with the RAM and register file.
interface io_port_if #(
    parameter int word_width = 16
);
    logic [word_width-1:0] addr;
    logic                  io_oe;
    logic                  io_we;
    logic [word_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [word_width-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  irq;

    modport master (
        output addr, io_oe, io_we, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, rx_ready, irq
    );

    modport slave (
        input  addr, io_oe, io_we, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, rx_ready, irq
    );
endinterface

// File: rtl/io_port.sv
// Memory-mapped I/O port: DATA/STATUS/CONTROL/SCRATCH at base_addr, bridging the shared bus
// to an RX and a TX valid/ready stream through small circular FIFOs.
module io_port #(
    parameter int                    word_width = 16,
    parameter logic [word_width-1:0] base_addr  = 16'hFF00,
    parameter int                    fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    io_port_if.slave              port,
    inout  wire  [word_width-1:0] bus
);
    localparam int         pw      = $clog2(fifo_depth);
    localparam logic [3:0] depth_c = 4'(fifo_depth);

    logic [word_width-1:0] rx_mem_r [fifo_depth];
    logic [word_width-1:0] tx_mem_r [fifo_depth];
    logic [pw-1:0]         rx_wr_ptr_r, rx_rd_ptr_r, tx_wr_ptr_r, tx_rd_ptr_r;
    logic [3:0]            rx_count_r, tx_count_r;
    logic                  rx_ie_r, rx_udf_r, tx_ovf_r;
    logic [word_width-1:0] scratch_r;

    logic                  sel_s, rd_s, wr_s;
    logic [1:0]            idx_s;
    logic                  rx_empty_s, tx_full_s, rx_ready_s, tx_valid_s, irq_s;
    logic                  rx_push_s, rx_pop_s, udf_set_s;
    logic                  tx_push_s, tx_pop_s, ovf_set_s;
    logic                  ctrl_wr_s, flush_s, clear_s, scratch_wr_s;
    logic [word_width-1:0] status_s, rd_data_s;

    // Address decode, access qualification and FIFO handshake conditions.
    always_comb begin
        sel_s        = (port.addr[word_width-1:2] == base_addr[word_width-1:2]);
        idx_s        = port.addr[1:0];
        rd_s         = sel_s & port.io_oe & ~port.io_we;
        wr_s         = sel_s & port.io_we;
        rx_empty_s   = (rx_count_r == 4'd0);
        tx_full_s    = (tx_count_r == depth_c);
        rx_ready_s   = (rx_count_r != depth_c);
        tx_valid_s   = (tx_count_r != 4'd0);
        irq_s        = rx_ie_r & ~rx_empty_s;
        rx_push_s    = port.rx_valid & rx_ready_s;
        rx_pop_s     = rd_s & (idx_s == 2'd0) & ~rx_empty_s;
        udf_set_s    = rd_s & (idx_s == 2'd0) & rx_empty_s;
        tx_pop_s     = tx_valid_s & port.tx_ready;
        // A full TX still accepts a bus word when the head leaves in the same cycle.
        tx_push_s    = wr_s & (idx_s == 2'd0) & (~tx_full_s | tx_pop_s);
        ovf_set_s    = wr_s & (idx_s == 2'd0) & tx_full_s & ~tx_pop_s;
        ctrl_wr_s    = wr_s & (idx_s == 2'd2);
        flush_s      = ctrl_wr_s & bus[2];
        clear_s      = ctrl_wr_s & bus[1];
        scratch_wr_s = wr_s & (idx_s == 2'd3);
    end

    // STATUS word assembly.
    always_comb begin
        status_s        = '0;
        status_s[0]     = ~rx_empty_s;
        status_s[1]     = tx_full_s;
        status_s[2]     = rx_udf_r;
        status_s[3]     = tx_ovf_r;
        status_s[4]     = irq_s;
        status_s[11:8]  = rx_count_r;
        status_s[15:12] = tx_count_r;
    end

    // Register read multiplexer; an empty DATA read returns zero.
    always_comb begin
        rd_data_s = '0;
        case (idx_s)
            2'd0: begin
                if (rx_empty_s) begin
                    rd_data_s = '0;
                end else begin
                    rd_data_s = rx_mem_r[rx_rd_ptr_r];
                end
            end
            2'd1:    rd_data_s = status_s;
            2'd2:    rd_data_s[0] = rx_ie_r;
            2'd3:    rd_data_s = scratch_r;
            default: rd_data_s = '0;
        endcase
    end

    assign bus           = rd_s ? rd_data_s : {word_width{1'bz}};
    assign port.tx_data  = tx_mem_r[tx_rd_ptr_r];
    assign port.tx_valid = tx_valid_s;
    assign port.rx_ready = rx_ready_s;
    assign port.irq      = irq_s;

    // FIFO storage/pointers, sticky flags and control/scratch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                rx_mem_r[i] <= '0;
                tx_mem_r[i] <= '0;
            end
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            rx_count_r  <= 4'd0;
            tx_count_r  <= 4'd0;
            rx_ie_r     <= 1'b0;
            rx_udf_r    <= 1'b0;
            tx_ovf_r    <= 1'b0;
            scratch_r   <= '0;
        end else begin
            if (flush_s) begin
                rx_wr_ptr_r <= '0;
                rx_rd_ptr_r <= '0;
                tx_wr_ptr_r <= '0;
                tx_rd_ptr_r <= '0;
                rx_count_r  <= 4'd0;
                tx_count_r  <= 4'd0;
            end else begin
                if (rx_push_s) begin
                    rx_mem_r[rx_wr_ptr_r] <= port.rx_data;
                    rx_wr_ptr_r           <= rx_wr_ptr_r + pw'(1);
                end
                if (rx_pop_s) begin
                    rx_rd_ptr_r <= rx_rd_ptr_r + pw'(1);
                end
                if (tx_push_s) begin
                    tx_mem_r[tx_wr_ptr_r] <= bus;
                    tx_wr_ptr_r           <= tx_wr_ptr_r + pw'(1);
                end
                if (tx_pop_s) begin
                    tx_rd_ptr_r <= tx_rd_ptr_r + pw'(1);
                end
                rx_count_r <= rx_count_r + 4'(rx_push_s) - 4'(rx_pop_s);
                tx_count_r <= tx_count_r + 4'(tx_push_s) - 4'(tx_pop_s);
            end
            rx_udf_r <= ~clear_s & (rx_udf_r | udf_set_s);
            tx_ovf_r <= ~clear_s & (tx_ovf_r | ovf_set_s);
            if (ctrl_wr_s) begin
                rx_ie_r <= bus[0];
            end
            if (scratch_wr_s) begin
                scratch_r <= bus;
            end
        end
    end
endmodule

// File: tb/tb_io_port.sv
// Scoreboard bench for io_port: a queue-based reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_io_port;
    localparam int depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_port_if #(.word_width(16)) ifc();
    wire  [15:0] bus;
    logic [15:0] drv    = 16'h0000;
    logic        drv_en = 1'b0;
    assign bus = drv_en ? drv : 16'hzzzz;
    pullup (bus);

    io_port #(.word_width(16), .base_addr(16'hFF00), .fifo_depth(depth)) dut (
        .clk (clk),
        .rst (rst),
        .port(ifc.slave),
        .bus (bus)
    );

    typedef struct {
        bit          chk;
        bit          chk_bus;
        logic [15:0] bus_v;
        bit          txv;
        bit          chk_txd;
        logic [15:0] txd;
        bit          rxr;
        bit          irq;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_rx[$];
    logic [15:0] m_tx[$];
    bit          m_ie, m_udf, m_ovf, m_fresh, m_known;
    logic [15:0] m_scr;
    bit          g_txr, g_rxv;
    logic [15:0] g_rxd;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s        = 16'h0000;
        s[0]     = (m_rx.size() != 0);
        s[1]     = (m_tx.size() == depth);
        s[2]     = m_udf;
        s[3]     = m_ovf;
        s[4]     = m_ie && (m_rx.size() != 0);
        s[11:8]  = 4'(m_rx.size());
        s[15:12] = 4'(m_tx.size());
        return s;
    endfunction

    // One bus cycle: apply inputs, predict outputs from the current model state, then advance the model.
    task automatic step(input bit r, input logic [15:0] a, input bit oe, input bit we, input logic [15:0] wd);
        exp_t e;
        bit   sel, txv, rxr, rd, wr, tx_pop, rx_push;
        int   idx, tx_n;
        @(posedge clk);
        #1;
        rst          = r;
        ifc.addr     = a;
        ifc.io_oe    = oe;
        ifc.io_we    = we;
        drv          = wd;
        drv_en       = we;
        ifc.tx_ready = g_txr;
        ifc.rx_valid = g_rxv;
        ifc.rx_data  = g_rxd;

        sel = (a[15:2] == 14'h3FC0);
        idx = int'(a[1:0]);
        rd  = sel && oe && !we;
        wr  = sel && we;
        txv = (m_tx.size() != 0);
        rxr = (m_rx.size() != depth);

        e.chk     = m_known;
        e.txv     = txv;
        e.chk_txd = txv || m_fresh;
        e.txd     = txv ? m_tx[0] : 16'h0000;
        e.rxr     = rxr;
        e.irq     = m_ie && (m_rx.size() != 0);
        e.chk_bus = !we;
        e.bus_v   = 16'hFFFF;
        if (rd) begin
            case (idx)
                0:       e.bus_v = (m_rx.size() != 0) ? m_rx[0] : 16'h0000;
                1:       e.bus_v = model_status();
                2:       e.bus_v = {15'h0000, m_ie};
                default: e.bus_v = m_scr;
            endcase
        end
        sbq.push_back(e);

        if (r) begin
            m_rx.delete();
            m_tx.delete();
            m_ie    = 1'b0;
            m_udf   = 1'b0;
            m_ovf   = 1'b0;
            m_scr   = 16'h0000;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else begin
            tx_pop  = txv && g_txr;
            rx_push = g_rxv && rxr;
            tx_n    = m_tx.size();
            if (wr && idx == 2) begin
                m_ie = wd[0];
                if (wd[1]) begin
                    m_udf = 1'b0;
                    m_ovf = 1'b0;
                end
            end
            if (wr && idx == 2 && wd[2]) begin
                m_rx.delete();
                m_tx.delete();
            end else begin
                if (tx_pop) void'(m_tx.pop_front());
                if (wr && idx == 0) begin
                    if (tx_n < depth || tx_pop) begin
                        m_tx.push_back(wd);
                        m_fresh = 1'b0;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (rd && idx == 0) begin
                    if (m_rx.size() == 0) m_udf = 1'b1;
                    else void'(m_rx.pop_front());
                end
                if (rx_push) m_rx.push_back(g_rxd);
            end
            if (wr && idx == 3) m_scr = wd;
        end
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        step(1'b0, a, 1'b0, 1'b1, d);
    endtask

    task automatic bus_rd(input logic [15:0] a);
        step(1'b0, a, 1'b1, 1'b0, 16'h0000);
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
                check("tx_valid", 16'(ifc.tx_valid), 16'(e.txv));
                check("rx_ready", 16'(ifc.rx_ready), 16'(e.rxr));
                check("irq", 16'(ifc.irq), 16'(e.irq));
                if (e.chk_txd) check("tx_data", ifc.tx_data, e.txd);
                if (e.chk_bus) check("bus", bus, e.bus_v);
            end
        end
    end

    initial begin
        logic [15:0] a, wd;
        int          k, op;
        ifc.addr = 16'h0000; ifc.io_oe = 1'b0; ifc.io_we = 1'b0;
        ifc.tx_ready = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 16'h0000;
        g_txr = 1'b0; g_rxv = 1'b0; g_rxd = 16'h0000;
        m_known = 1'b0; m_fresh = 1'b1;

        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        bus_rd(16'hFF01);
        step(1'b0, 16'hFF01, 1'b0, 1'b0, 16'h0000);

        // TX fill past full, then drain.
        for (int i = 0; i < 5; i++) bus_wr(16'hFF00, 16'h0041 + 16'(i));
        bus_rd(16'hFF01);
        g_txr = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        bus_wr(16'hFF02, 16'h0002);

        // RX with interrupt, then underflow.
        g_rxv = 1'b1; g_rxd = 16'h1234; idle();
        g_rxd = 16'h5678; idle();
        g_rxv = 1'b0;
        bus_wr(16'hFF02, 16'h0001);
        idle();
        for (int i = 0; i < 3; i++) bus_rd(16'hFF00);
        bus_rd(16'hFF01);

        // RX full with simultaneous bus pop and upstream offer.
        g_rxv = 1'b1;
        for (int i = 0; i < 4; i++) begin g_rxd = 16'hA000 + 16'(i); idle(); end
        g_rxd = 16'hA004;
        bus_rd(16'hFF00);
        idle();
        g_rxv = 1'b0;
        bus_rd(16'hFF01);
        for (int i = 0; i < 5; i++) bus_rd(16'hFF00);

        // Scratch and deselected accesses.
        bus_wr(16'hFF03, 16'hBEEF);
        bus_rd(16'hFF03);
        bus_wr(16'h0003, 16'h1111);
        bus_rd(16'hFF03);
        bus_rd(16'h0003);

        // Flush with both FIFOs occupied and both flags set.
        g_txr = 1'b0;
        for (int i = 0; i < 5; i++) bus_wr(16'hFF00, 16'h0100 + 16'(i));
        g_rxv = 1'b1; g_rxd = 16'h0777; idle(); g_rxv = 1'b0;
        bus_rd(16'hFF01);
        bus_wr(16'hFF02, 16'h0006);
        bus_rd(16'hFF01);

        // Reset in the middle of TX streaming.
        for (int i = 0; i < 3; i++) bus_wr(16'hFF00, 16'h0200 + 16'(i));
        g_txr = 1'b1;
        idle();
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        idle();
        idle();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            k  = int'($urandom_range(0, 9));
            op = int'($urandom_range(0, 3));
            if (k < 8) a = 16'hFF00 | 16'(k % 4);
            else if (k == 8) a = 16'h0003;
            else a = 16'($urandom);
            wd = 16'($urandom);
            if (a[1:0] == 2'd2 && $urandom_range(0, 7) != 0) wd[2] = 1'b0;
            g_txr = ($urandom_range(0, 2) != 0);
            g_rxv = ($urandom_range(0, 1) != 0);
            g_rxd = 16'($urandom);
            step(($urandom_range(0, 199) == 0), a, (op == 1 || op == 3), (op == 2 || op == 3), wd);
        end
        g_txr = 1'b0; g_rxv = 1'b0;
        idle();
        idle();
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
